// File: rtl/text_buffer_writer.sv
// Write-side engine for the ASCII character buffer: turns a byte stream into
// character RAM writes, tracks the cursor and performs line/screen clears.
module text_buffer_writer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter int          AW    = 12,
  parameter logic [7:0]  BLANK = 8'h20,
  localparam int         CW    = $clog2(COLS),
  localparam int         RW    = $clog2(ROWS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    char_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          we_o,
  output logic [AW-1:0] wad_o,
  output logic [7:0]    wdata_o,
  output logic [CW-1:0] cur_col_o,
  output logic [RW-1:0] cur_row_o,
  output logic [1:0]    dbg_state_o
);

  // Handshake: a byte transfers on a rising edge where valid_i & ready_o;
  // the source holds char_i/valid_i stable while ready_o is low.

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  localparam int            TOTAL    = COLS * ROWS;
  localparam logic [AW:0]   CNT_ALL  = (AW+1)'(TOTAL);
  localparam logic [AW:0]   CNT_ROW  = (AW+1)'(COLS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] col_d;
  logic [RW-1:0] row_d;
  logic [AW-1:0] base_q, base_d;
  logic          ready_d, we_d;
  logic [AW-1:0] wad_d;
  logic [7:0]    wdata_d;
  logic [RW-1:0] row_adv;
  logic [AW-1:0] base_adv;
  logic          accept;

  assign dbg_state_o = state_q;
  assign accept      = valid_i & ready_o;

  // No scrolling: the last row wraps back to the top of the screen.
  always_comb begin
    row_adv  = (cur_row_o == ROW_LAST) ? '0 : cur_row_o + RW'(1);
    base_adv = (cur_row_o == ROW_LAST) ? '0 : base_q + AW'(COLS);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = cur_col_o;
    row_d   = cur_row_o;
    base_d  = base_q;
    ready_d = 1'b0;
    we_d    = 1'b0;
    wad_d   = wad_o;
    wdata_d = wdata_o;
    case (state_q)
      CLR_ALL: begin
        // Count runs one past the last address so ready rises a cycle after the final write.
        if (cnt_q == CNT_ALL) begin
          state_d = IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
        end else begin
          we_d    = 1'b1;
          wad_d   = cnt_q[AW-1:0];
          wdata_d = BLANK;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      CLR_ROW: begin
        if (cnt_q == CNT_ROW) begin
          state_d = IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          we_d    = 1'b1;
          wad_d   = base_q + cnt_q[AW-1:0];
          wdata_d = BLANK;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          if (char_i >= 8'h20 && char_i <= 8'h7E) begin
            we_d    = 1'b1;
            wad_d   = base_q + AW'(cur_col_o);
            wdata_d = char_i;
            if (cur_col_o == COL_LAST) begin
              col_d   = '0;
              row_d   = row_adv;
              base_d  = base_adv;
              cnt_d   = '0;
              state_d = CLR_ROW;
              ready_d = 1'b0;
            end else begin
              col_d = cur_col_o + CW'(1);
            end
          end else if (char_i == 8'h0A) begin
            // The first blank write of the new row issues on the accept edge.
            col_d   = '0;
            row_d   = row_adv;
            base_d  = base_adv;
            we_d    = 1'b1;
            wad_d   = base_adv;
            wdata_d = BLANK;
            cnt_d   = (AW+1)'(1);
            state_d = CLR_ROW;
            ready_d = 1'b0;
          end else if (char_i == 8'h0D) begin
            col_d = '0;
          end else if (char_i == 8'h08) begin
            if (cur_col_o != '0) begin
              col_d   = cur_col_o - CW'(1);
              we_d    = 1'b1;
              wad_d   = base_q + AW'(cur_col_o - CW'(1));
              wdata_d = BLANK;
            end
          end else if (char_i == 8'h0C) begin
            we_d    = 1'b1;
            wad_d   = '0;
            wdata_d = BLANK;
            cnt_d   = (AW+1)'(1);
            state_d = CLR_ALL;
            ready_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = CLR_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= CLR_ALL;
      cnt_q     <= '0;
      base_q    <= '0;
      cur_col_o <= '0;
      cur_row_o <= '0;
      ready_o   <= 1'b0;
      we_o      <= 1'b0;
      wad_o     <= '0;
      wdata_o   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      cur_col_o <= col_d;
      cur_row_o <= row_d;
      ready_o   <= ready_d;
      we_o      <= we_d;
      wad_o     <= wad_d;
      wdata_o   <= wdata_d;
    end
  end

endmodule
